// File: rtl/mm_pkg.sv
// Shared types and helpers for the matrix-matrix multiplier loader.
package mm_pkg;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        FLUSH,
        START,
        WAIT_DONE
    } mm_ld_state_t;

    // Address width that never collapses to zero bits for tiny N.
    function automatic int mm_aw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mm_lane_decoder.sv
// Turns a lane index plus a write request into a one-hot (or zero) lane write-enable vector.
module mm_lane_decoder
    import mm_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = mm_aw(N)
) (
    input  logic [AW-1:0] lane,
    input  logic          we_req,
    output logic [0:N-1]  we
);

    always_comb begin
        we = '0;
        for (int i = 0; i < N; i++) begin
            we[i] = we_req && (lane == AW'(i));
        end
    end

endmodule

// File: rtl/mm_loader.sv
// Streams N*N A elements (row-major) then N*N B elements (column-major) into the lane memories,
// then starts the multiplier and waits for done. Optional checksum output: MM_LOADER_CHECKSUM_EN.
module mm_loader
    import mm_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    // Handshake: an element moves when in_valid && in_ready on a rising edge; in_ready depends
    // only on state, and the producer must hold in_data while in_valid is high and in_ready low.
    input  logic [DW-1:0]               in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [N-1:0][DW-1:0]        rom_mat_a_data,
    output logic [N-1:0][mm_aw(N)-1:0]  rom_mat_a_wr_addr,
    output logic [0:N-1]                rom_mat_a_we,
    output logic [N-1:0][DW-1:0]        rom_mat_b_data,
    output logic [N-1:0][mm_aw(N)-1:0]  rom_mat_b_wr_addr,
    output logic [0:N-1]                rom_mat_b_we,
    output logic                        start,
    input  logic                        mm_done,
    output mm_ld_state_t                dbg_state,
    output logic                        busy
`ifdef MM_LOADER_CHECKSUM_EN
   ,output logic [2*DW+2*mm_aw(N)-1:0]  chk_sum
`endif
);

    localparam int AW = mm_aw(N);
    localparam int CW = 2 * DW + 2 * AW;

    mm_ld_state_t  state;
    logic [AW-1:0] addr_cnt;
    logic [AW-1:0] lane_cnt;
    logic [DW-1:0] wr_data_q;
    logic [AW-1:0] wr_addr_q;
    logic [AW-1:0] wr_lane_q;
    logic          we_a_q;
    logic          we_b_q;
    logic          xfer;
    logic          last_elem;

    assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign xfer      = in_valid && in_ready;
    assign last_elem = (addr_cnt == AW'(N - 1)) && (lane_cnt == AW'(N - 1));
    assign busy      = (state != LOAD_A) || (lane_cnt != '0) || (addr_cnt != '0);
    assign dbg_state = state;

`ifdef MM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_sum <= '0;
        end else if (xfer) begin
            chk_sum <= chk_sum + CW'(in_data);
        end else if ((state == WAIT_DONE) && mm_done) begin
            chk_sum <= '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD_A;
            addr_cnt  <= '0;
            lane_cnt  <= '0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            wr_lane_q <= '0;
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
            start     <= 1'b0;
        end else begin
            we_a_q <= 1'b0;
            we_b_q <= 1'b0;
            start  <= 1'b0;

            // Element (lane_cnt, addr_cnt) lands on lane lane_cnt at address addr_cnt for both
            // matrices; column-major B order makes lane_cnt the column there.
            if (xfer) begin
                wr_data_q <= in_data;
                wr_addr_q <= addr_cnt;
                wr_lane_q <= lane_cnt;
                we_a_q    <= (state == LOAD_A);
                we_b_q    <= (state == LOAD_B);
                if (last_elem) begin
                    addr_cnt <= '0;
                    lane_cnt <= '0;
                end else if (addr_cnt == AW'(N - 1)) begin
                    addr_cnt <= '0;
                    lane_cnt <= lane_cnt + 1'b1;
                end else begin
                    addr_cnt <= addr_cnt + 1'b1;
                end
            end

            case (state)
                LOAD_A: begin
                    if (xfer && last_elem) state <= LOAD_B;
                end
                LOAD_B: begin
                    if (xfer && last_elem) state <= FLUSH;
                end
                FLUSH: begin
                    state <= START;
                    start <= 1'b1;
                end
                START: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (mm_done) begin
                        state    <= LOAD_A;
                        addr_cnt <= '0;
                        lane_cnt <= '0;
                    end
                end
                default: begin
                    state <= LOAD_A;
                end
            endcase
        end
    end

    mm_lane_decoder #(.N(N), .AW(AW)) u_dec_a (
        .lane   (wr_lane_q),
        .we_req (we_a_q),
        .we     (rom_mat_a_we)
    );

    mm_lane_decoder #(.N(N), .AW(AW)) u_dec_b (
        .lane   (wr_lane_q),
        .we_req (we_b_q),
        .we     (rom_mat_b_we)
    );

    // Every lane sees the same data/address; the write enable picks the lane.
    for (genvar g = 0; g < N; g++) begin : g_lane
        assign rom_mat_a_data[g]    = wr_data_q;
        assign rom_mat_a_wr_addr[g] = wr_addr_q;
        assign rom_mat_b_data[g]    = wr_data_q;
        assign rom_mat_b_wr_addr[g] = wr_addr_q;
    end

endmodule

// File: tb/tb_mm_loader.sv
// Self-checking bench for mm_loader (N=4, DW=2) against a transaction-level reference model.
module tb_mm_loader;
    import mm_pkg::*;

    localparam int N  = 4;
    localparam int DW = 2;
    localparam int AW = 2;
    localparam int NN = N * N;
    localparam int TOT = 2 * NN;
    localparam int W  = 1 + 2 * AW + DW;
    localparam int CW = 2 * DW + 2 * AW;

    logic                   clk;
    logic                   rst;
    logic [DW-1:0]          in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [N-1:0][DW-1:0]   rom_mat_a_data;
    logic [N-1:0][AW-1:0]   rom_mat_a_wr_addr;
    logic [0:N-1]           rom_mat_a_we;
    logic [N-1:0][DW-1:0]   rom_mat_b_data;
    logic [N-1:0][AW-1:0]   rom_mat_b_wr_addr;
    logic [0:N-1]           rom_mat_b_we;
    logic                   start;
    logic                   mm_done;
    mm_ld_state_t           dbg_state;
    logic                   busy;
`ifdef MM_LOADER_CHECKSUM_EN
    logic [CW-1:0]          chk_sum;
`endif

    mm_loader #(.N(N), .DW(DW)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .rom_mat_a_data    (rom_mat_a_data),
        .rom_mat_a_wr_addr (rom_mat_a_wr_addr),
        .rom_mat_a_we      (rom_mat_a_we),
        .rom_mat_b_data    (rom_mat_b_data),
        .rom_mat_b_wr_addr (rom_mat_b_wr_addr),
        .rom_mat_b_we      (rom_mat_b_we),
        .start             (start),
        .mm_done           (mm_done),
        .dbg_state         (dbg_state),
        .busy              (busy)
`ifdef MM_LOADER_CHECKSUM_EN
       ,.chk_sum           (chk_sum)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model and scoreboard
    int            vectors;
    int            miscompares;
    int            cyc;
    int            n_acc;
    int            fin_tick;
    int            we_total;
    int            sum_model;
    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] stream [TOT];
    logic [DW-1:0] mem_a [N][N];
    logic [DW-1:0] mem_b [N][N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected write for the k-th accepted element of a load: {is_b, lane, addr, data}.
    function automatic logic [W-1:0] exp_write(input int k, input logic [DW-1:0] d);
        int r, c;
        if (k < NN) begin
            r = k / N; c = k % N;
            return {1'b0, AW'(r), AW'(c), d};
        end
        c = (k - NN) / N; r = (k - NN) % N;
        return {1'b1, AW'(c), AW'(r), d};
    endfunction

    // One clock: predict, step, then check every output against the model.
    task automatic tick();
        logic          xfer, done_taken;
        logic [DW-1:0] d;
        int            cnt, lane;
        logic          isb;
        logic [W-1:0]  got;
        xfer       = !rst && in_valid && (n_acc < TOT);
        done_taken = !rst && mm_done && (n_acc == TOT) && (cyc >= fin_tick + 2);
        d          = in_data;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            n_acc = 0; sum_model = 0; fin_tick = -100; exp_q.delete();
        end else begin
            if (xfer) begin
                exp_q.push_back(exp_write(n_acc, d));
                sum_model += int'(d);
                n_acc++;
                if (n_acc == TOT) fin_tick = cyc;
            end
            if (done_taken) begin
                n_acc = 0; sum_model = 0; fin_tick = -100;
            end
        end

        cnt = 0; lane = 0; isb = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rom_mat_a_we[i]) begin cnt++; lane = i; isb = 1'b0; end
            if (rom_mat_b_we[i]) begin cnt++; lane = i; isb = 1'b1; end
        end
        check("we_count", cnt, (xfer ? 1 : 0));
        if (cnt == 1) begin
            we_total++;
            if (!isb) begin
                got = {1'b0, AW'(lane), rom_mat_a_wr_addr[lane], rom_mat_a_data[lane]};
                mem_a[lane][rom_mat_a_wr_addr[lane]] = rom_mat_a_data[lane];
            end else begin
                got = {1'b1, AW'(lane), rom_mat_b_wr_addr[lane], rom_mat_b_data[lane]};
                mem_b[lane][rom_mat_b_wr_addr[lane]] = rom_mat_b_data[lane];
            end
            if (exp_q.size() > 0) check("write", 32'(got), 32'(exp_q.pop_front()));
            else check("write_unexpected", 1, 0);
        end
        check("in_ready", in_ready, (n_acc < TOT));
        check("busy", busy, (n_acc != 0));
        check("start", start, (fin_tick >= 0 && cyc == fin_tick + 1));
`ifdef MM_LOADER_CHECKSUM_EN
        if (n_acc == TOT || n_acc == 0) check("chk_sum", 32'(chk_sum), 32'(sum_model));
`endif
    endtask

    // driver: one full load plus the start/done handshake
    task automatic run_load(input int mode, input int valid_pct, input bit done_noise,
                            input bit done_in_start, input int hold_cycles);
        int budget, we_start;
        for (int k = 0; k < TOT; k++) begin
            if (mode == 2) stream[k] = DW'(3);
            else if (k < NN) stream[k] = DW'((k + 1) % 4);
            else stream[k] = DW'(((k - NN) / N) == ((k - NN) % N));
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mem_a[r][c] = 'x; mem_b[r][c] = 'x;
            end
        we_start = we_total;
        budget = 0;
        while (n_acc < TOT && budget < 600) begin
            in_valid = ($urandom_range(0, 99) < valid_pct);
            in_data  = in_valid ? stream[n_acc] : DW'($urandom);
            mm_done  = done_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            tick();
            budget++;
        end
        check("load_complete", n_acc, TOT);
`ifdef MM_LOADER_CHECKSUM_EN
        if (mode == 2) check("chk_sum_96", 32'(chk_sum), 96);
`endif
        in_valid = 1'b0;
        mm_done  = 1'b0;
        tick();
        mm_done = done_in_start;
        tick();
        mm_done = 1'b0;
        for (int i = 0; i < hold_cycles; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("we_total", we_total - we_start, TOT);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                check("mem_a", 32'(mem_a[r][c]), 32'(stream[r * N + c]));
                check("mem_b", 32'(mem_b[c][r]), 32'(stream[NN + c * N + r]));
            end
        mm_done = 1'b1;
        tick();
        mm_done = 1'b0;
        tick();
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; n_acc = 0; fin_tick = -100;
        we_total = 0; sum_model = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; mm_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // directed: full-rate load, then random valid gaps
        run_load(0, 100, 1'b0, 1'b0, 3);
        run_load(1, 50, 1'b0, 1'b0, 3);
        // blocked producer while waiting for done
        run_load(0, 100, 1'b0, 1'b0, 20);
        // reset after 10 A transfers, then a fresh load
        in_valid = 1'b1;
        while (n_acc < 10 && cyc < 5000) begin
            in_data = DW'($urandom);
            tick();
        end
        check("partial_count", n_acc, 10);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_we", 32'({rom_mat_a_we, rom_mat_b_we}), 0);
        run_load(1, 70, 1'b0, 1'b0, 2);
        // stray mm_done during LOAD_A/LOAD_B and in START
        run_load(0, 80, 1'b1, 1'b1, 4);
        run_load(2, 60, 1'b0, 1'b1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
